// File: rtl/rr_decoder_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant.
// Each grant is held until done, requester drop, or the HOLD_MAX cycle limit.
module rr_decoder_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HoldLim = 4'(HOLD_MAX - 1);

    state_t      state_q;
    logic [2:0]  ptr_q;
    logic [3:0]  hold_q;
    logic [7:0]  gnt_q;
    logic [2:0]  idx_q;
    logic        valid_q;
    logic        tmo_q;

    logic [15:0] req2;
    logic [7:0]  rot;
    logic [2:0]  off;
    logic [2:0]  idx_d;
    logic        rel;

    // Rotate so that bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req2 = {req, req} >> ptr_q;
        rot  = req2[7:0];
        off  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        idx_d = ptr_q + off;
        rel   = done || !req[idx_q] || (hold_q == HoldLim);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_q <= 1'b0;
                    if (|req) begin
                        state_q <= BUSY;
                        idx_q   <= idx_d;
                        gnt_q   <= 8'h01 << idx_d;
                        valid_q <= 1'b1;
                        hold_q  <= 4'd0;
                    end
                end
                BUSY: begin
                    hold_q <= hold_q + 4'd1;
                    if (rel) begin
                        state_q <= IDLE;
                        ptr_q   <= idx_q + 3'd1;
                        gnt_q   <= 8'h00;
                        valid_q <= 1'b0;
                        tmo_q   <= !done && req[idx_q];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed self-checking bench for rr_decoder_arbiter.
// Main instance uses HOLD_MAX=4; a second instance checks HOLD_MAX=1.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [7:0] g1;
    logic [2:0] i1;
    logic       v1;
    logic       t1;

    int checks = 0;
    int failures = 0;

    rr_decoder_arbiter #(.HOLD_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_decoder_arbiter #(.HOLD_MAX(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(g1), .gnt_idx(i1),
        .gnt_valid(v1), .timeout(t1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 ||
                gnt_idx !== 3'd0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold act=%h/%b/%0d/%b exp=00/0/0/0",
                         gnt, gnt_valid, gnt_idx, timeout);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_first_grant act=%h/%b/%0d exp=01/1/0",
                     gnt, gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL single_grant%0d act=%h/%0d exp=08/3",
                         k, gnt, gnt_idx);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 ||
            gnt_idx !== 3'd3 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_release act=%h/%b/%0d/%b exp=00/0/3/0",
                     gnt, gnt_valid, gnt_idx, timeout);
        end
        step();
        checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            failures++;
            $display("FAIL single_regrant act=%h/%0d exp=08/3", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_rotation();
        logic [7:0] exp;
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = 8'h01 << k;
            step();
            checks++;
            if (gnt !== exp || gnt_idx !== 3'(k)) begin
                failures++;
                $display("FAIL rot_grant%0d act=%h/%0d exp=%h/%0d",
                         k, gnt, gnt_idx, exp, k);
            end
            step();
            checks++;
            if (gnt !== 8'h00 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL rot_bubble%0d act=%h/%b exp=00/0",
                         k, gnt, timeout);
            end
        end
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL rot_wrap act=%h/%0d exp=01/0", gnt, gnt_idx);
        end
        done = 1'b0;
        req  = 8'h00;
        step();
    endtask

    task automatic test_hold_limit();
        do_reset();
        req = 8'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (gnt !== 8'h20 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_grant%0d act=%h/%b exp=20/0",
                         k, gnt, timeout);
            end
        end
        step();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_timeout act=%h/%b exp=00/1", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 8'h20 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL hold_regrant act=%h/%b exp=20/0", gnt, timeout);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 8'h20;
        repeat (4) step();
        checks++;
        if (gnt !== 8'h20) begin
            failures++;
            $display("FAIL simul_grant4 act=%h exp=20", gnt);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL simul_done_wins act=%h/%b exp=00/0", gnt, timeout);
        end
        do_reset();
        req = 8'h24;
        step();
        step();
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            failures++;
            $display("FAIL drop_grant act=%h/%0d exp=04/2", gnt, gnt_idx);
        end
        req = 8'h20;
        step();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_release act=%h/%b exp=00/0", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
            failures++;
            $display("FAIL drop_next act=%h/%0d exp=20/5", gnt, gnt_idx);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h40;
        step();
        checks++;
        if (gnt !== 8'h40) begin
            failures++;
            $display("FAIL mid_grant act=%h exp=40", gnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_async act=%h/%b exp=00/0", gnt, gnt_valid);
        end
        step();
        rst = 1'b0;
        req = 8'h41;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL mid_ptr act=%h/%0d exp=01/0", gnt, gnt_idx);
        end
        do_reset();
        req = 8'h20;
        repeat (5) step();
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL mid_tmo_setup act=%b exp=1", timeout);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL mid_tmo_clear act=%b exp=0", timeout);
        end
        step();
        rst = 1'b0;
        req = 8'h00;
        step();
    endtask

    task automatic test_hold_one();
        do_reset();
        req = 8'h02;
        step();
        checks++;
        if (g1 !== 8'h02 || i1 !== 3'd1 || v1 !== 1'b1) begin
            failures++;
            $display("FAIL h1_grant act=%h/%0d exp=02/1", g1, i1);
        end
        step();
        checks++;
        if (g1 !== 8'h00 || t1 !== 1'b1) begin
            failures++;
            $display("FAIL h1_timeout act=%h/%b exp=00/1", g1, t1);
        end
        step();
        checks++;
        if (g1 !== 8'h02 || t1 !== 1'b0) begin
            failures++;
            $display("FAIL h1_regrant act=%h/%b exp=02/0", g1, t1);
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_rotation();
        test_hold_limit();
        test_simultaneous();
        test_reset_mid();
        test_hold_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
